// File: rtl/branch_pht_if.sv
// branch_pht_if: lookup/predict/update bundle between fetch, execute and the pattern history table.
// BRANCH_PHT_GSHARE_EN adds the history snapshot signals.
interface branch_pht_if #(
    parameter int PC_W     = 32,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 4
);
    logic                lookup_valid;
    logic [PC_W-1:0]     lookup_pc;
    logic                pred_valid;
    logic                pred_taken;
    logic [CTR_BITS-1:0] pred_ctr;
    logic                upd_valid;
    logic [PC_W-1:0]     upd_pc;
    logic                upd_taken;
`ifdef BRANCH_PHT_GSHARE_EN
    logic [GHR_BITS-1:0] pred_ghr;
    logic [GHR_BITS-1:0] upd_ghr;
`endif
    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken,
`ifdef BRANCH_PHT_GSHARE_EN
        output upd_ghr,
        input  pred_ghr,
`endif
        input  pred_valid, pred_taken, pred_ctr
    );
    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken,
`ifdef BRANCH_PHT_GSHARE_EN
        input  upd_ghr,
        output pred_ghr,
`endif
        output pred_valid, pred_taken, pred_ctr
    );
endinterface

// File: rtl/branch_pht.sv
// branch_pht: 2^INDEX_BITS saturating-counter pattern history table, 1-cycle registered lookup, write-first update bypass.
// Define BRANCH_PHT_GSHARE_EN for gshare indexing (PC index XOR global history); default is bimodal.
module branch_pht #(
    parameter int PC_W       = 32,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int INIT_CTR   = 1,
    parameter int GHR_BITS   = 4
) (
    input logic          clk,
    input logic          rst_n,
    branch_pht_if.slave  bus
);
    localparam int                  ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CMAX    = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CINIT   = CTR_BITS'(INIT_CTR);

    logic [CTR_BITS-1:0]   tbl [ENTRIES];
    logic [INDEX_BITS-1:0] lidx, uidx;
    logic [CTR_BITS-1:0]   cur, nxt, rd;
    logic [CTR_BITS-1:0]   pred_ctr_q;
    logic                  pred_valid_q;

`ifdef BRANCH_PHT_GSHARE_EN
    logic [GHR_BITS-1:0] ghr, pred_ghr_q;
    logic                unused_bits;
    assign lidx = bus.lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
    assign uidx = bus.upd_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(bus.upd_ghr);
    assign bus.pred_ghr = pred_ghr_q;
    assign unused_bits = ^{bus.lookup_pc, bus.upd_pc};
    // Lookup uses the history as it stood before this edge's shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr        <= '0;
            pred_ghr_q <= '0;
        end else begin
            if (bus.upd_valid) ghr <= GHR_BITS'({ghr, bus.upd_taken});
            if (bus.lookup_valid) pred_ghr_q <= ghr;
        end
    end
`else
    logic unused_bits;
    assign lidx = bus.lookup_pc[INDEX_BITS+1:2];
    assign uidx = bus.upd_pc[INDEX_BITS+1:2];
    assign unused_bits = ^{bus.lookup_pc, bus.upd_pc, 32'(GHR_BITS)};
`endif

    always_comb begin
        cur = tbl[uidx];
        nxt = bus.upd_taken ? (cur == CMAX ? cur : cur + 1'b1)
                            : (cur == '0   ? cur : cur - 1'b1);
        rd  = (bus.upd_valid && uidx == lidx) ? nxt : tbl[lidx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= CINIT;
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
        end else begin
            pred_valid_q <= bus.lookup_valid;
            if (bus.lookup_valid) pred_ctr_q <= rd;
            if (bus.upd_valid) tbl[uidx] <= nxt;
        end
    end

    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_ctr   = pred_ctr_q;
    assign bus.pred_taken = pred_ctr_q[CTR_BITS-1];
endmodule

// File: tb/tb_branch_pht.sv
// tb_branch_pht: directed checks of the default bimodal table (INDEX_BITS=4, CTR_BITS=2, INIT_CTR=1).
module tb_branch_pht;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_pht_if #(.PC_W(32), .CTR_BITS(2), .GHR_BITS(4)) bus ();
    branch_pht #(.PC_W(32), .INDEX_BITS(4), .CTR_BITS(2), .INIT_CTR(1), .GHR_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pred(input string tag, input logic v, input logic t, input logic [1:0] c);
        chk({tag, ".valid"}, 32'(bus.pred_valid), 32'(v));
        chk({tag, ".taken"}, 32'(bus.pred_taken), 32'(t));
        chk({tag, ".ctr"}, 32'(bus.pred_ctr), 32'(c));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic lv, input logic [31:0] lpc, input logic uv, input logic [31:0] upc, input logic ut);
        bus.lookup_valid = lv;
        bus.lookup_pc    = lpc;
        bus.upd_valid    = uv;
        bus.upd_pc       = upc;
        bus.upd_taken    = ut;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.lookup_valid = 1'b0;
        bus.lookup_pc    = '0;
        bus.upd_valid    = 1'b0;
        bus.upd_pc       = '0;
        bus.upd_taken    = 1'b0;
`ifdef BRANCH_PHT_GSHARE_EN
        bus.upd_ghr      = '0;
`endif
        @(posedge clk);
        #1;
        pred("reset", 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;

        cyc(1, 32'h40, 0, 0, 0);            pred("lk40_init", 1, 0, 2'b01);
        cyc(0, 32'h40, 0, 0, 0);            pred("idle_hold", 0, 0, 2'b01);

        cyc(1, 32'h40, 1, 32'h40, 1);       pred("inc1", 1, 1, 2'b10);
        cyc(1, 32'h40, 1, 32'h40, 1);       pred("inc2", 1, 1, 2'b11);
        cyc(1, 32'h40, 1, 32'h40, 1);       pred("inc_sat", 1, 1, 2'b11);
        cyc(1, 32'h40, 0, 0, 0);            pred("lk40_sat", 1, 1, 2'b11);

        cyc(1, 32'h40, 1, 32'h40, 0);       pred("dec1", 1, 1, 2'b10);
        cyc(1, 32'h40, 1, 32'h40, 0);       pred("dec2", 1, 0, 2'b01);
        cyc(0, 32'h40, 1, 32'h40, 0);       pred("dec3_nolk", 0, 0, 2'b01);
        cyc(1, 32'h40, 1, 32'h40, 0);       pred("dec_sat", 1, 0, 2'b00);
        cyc(1, 32'h40, 0, 0, 0);            pred("lk40_zero", 1, 0, 2'b00);

        cyc(1, 32'h44, 1, 32'h44, 1);       pred("bypass44", 1, 1, 2'b10);
        cyc(1, 32'h48, 1, 32'h44, 1);       pred("indep48", 1, 0, 2'b01);
        cyc(1, 32'h44, 0, 0, 0);            pred("lk44", 1, 1, 2'b11);

        cyc(0, 0, 1, 32'h0C, 1);
        cyc(1, 32'hFFFF_FF4F, 0, 0, 0);     pred("alias_idx3", 1, 1, 2'b10);
        cyc(1, 32'h10C, 1, 32'h8000_004E, 0); pred("alias_bypass", 1, 0, 2'b01);

        cyc(1, 32'h44, 0, 0, 0);            pred("pre_rst", 1, 1, 2'b11);
        #2 rst_n = 1'b0;
        #1 pred("async_rst", 0, 0, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 32'h40, 0, 0, 0);            pred("rst_40", 1, 0, 2'b01);
        cyc(1, 32'h44, 0, 0, 0);            pred("rst_44", 1, 0, 2'b01);
        cyc(1, 32'h4C, 0, 0, 0);            pred("rst_4c", 1, 0, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
